// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the four-digit BCD seven-segment display.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  // Scan position, units first; the encoding matches the nibble index in bcd.
  typedef enum logic [1:0] {
    DIG_UNITS     = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_HUNDREDS  = 2'd2,
    DIG_THOUSANDS = 2'd3
  } digit_pos_e;

  // Next scan position, wrapping from thousands back to units.
  function automatic digit_pos_e nextDigit(input digit_pos_e cur);
    digit_pos_e nxt;
    nxt = DIG_UNITS;
    case (cur)
      DIG_UNITS:     nxt = DIG_TENS;
      DIG_TENS:      nxt = DIG_HUNDREDS;
      DIG_HUNDREDS:  nxt = DIG_THOUSANDS;
      DIG_THOUSANDS: nxt = DIG_UNITS;
      default:       nxt = DIG_UNITS;
    endcase
    return nxt;
  endfunction

  // Active-low one-hot anode pattern for a scan position.
  function automatic logic [NUM_DIGITS-1:0] anForDigit(input digit_pos_e pos);
    logic [NUM_DIGITS-1:0] anVal;
    anVal = AN_OFF;
    case (pos)
      DIG_UNITS:     anVal = 4'b1110;
      DIG_TENS:      anVal = 4'b1101;
      DIG_HUNDREDS:  anVal = 4'b1011;
      DIG_THOUSANDS: anVal = 4'b0111;
      default:       anVal = AN_OFF;
    endcase
    return anVal;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles show a dash so a corrupted upstream value is visible.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Map each decimal digit to its pattern; anything above 9 becomes a dash.
  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// The whole BCD word is captured at once so a scan never mixes old and new
// digits, and an/seg are registered so they change cleanly on clock edges.
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic                    bcd_valid,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] dispReg_q, dispReg_d;
  logic [CNT_W-1:0]        refreshCnt_q, refreshCnt_d;
  digit_pos_e              digitIdx_q, digitIdx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic [3:0] nibble3, nibble2, nibble1, nibble0;
  logic [3:0] selNibble;
  logic [6:0] decodedSeg;
  logic       blankSlot;

  assign nibble3 = dispReg_q[15:12];
  assign nibble2 = dispReg_q[11:8];
  assign nibble1 = dispReg_q[7:4];
  assign nibble0 = dispReg_q[3:0];

  // Capture the full word on a valid strobe and step the refresh counter,
  // moving to the next digit only when the counter wraps.
  always_comb begin
    dispReg_d    = dispReg_q;
    refreshCnt_d = refreshCnt_q + CNT_W'(1);
    digitIdx_d   = digitIdx_q;
    if (bcd_valid) begin
      dispReg_d = bcd;
    end
    if (refreshCnt_q == CNT_MAX) begin
      refreshCnt_d = '0;
      digitIdx_d   = nextDigit(digitIdx_q);
    end
  end

  // Pick the nibble being scanned and decide whether it is a leading zero
  // that should be dark; the units digit is always shown.
  always_comb begin
    selNibble = nibble0;
    blankSlot = 1'b0;
    case (digitIdx_q)
      DIG_UNITS: begin
        selNibble = nibble0;
        blankSlot = 1'b0;
      end
      DIG_TENS: begin
        selNibble = nibble1;
        blankSlot = blank_lz && (nibble3 == 4'd0) && (nibble2 == 4'd0) && (nibble1 == 4'd0);
      end
      DIG_HUNDREDS: begin
        selNibble = nibble2;
        blankSlot = blank_lz && (nibble3 == 4'd0) && (nibble2 == 4'd0);
      end
      DIG_THOUSANDS: begin
        selNibble = nibble3;
        blankSlot = blank_lz && (nibble3 == 4'd0);
      end
      default: begin
        selNibble = nibble0;
        blankSlot = 1'b0;
      end
    endcase
  end

  seg7_decode uDecode (
    .nibble_i (selNibble),
    .seg_o    (decodedSeg)
  );

  // Form the next anode/segment values; a blanked slot turns everything off
  // but keeps its place in the scan so the refresh rate is unaffected.
  always_comb begin
    an_d  = anForDigit(digitIdx_q);
    seg_d = decodedSeg;
    if (blankSlot) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end
  end

  // State and output registers; reset dominates a simultaneous capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      dispReg_q    <= '0;
      refreshCnt_q <= '0;
      digitIdx_q   <= DIG_UNITS;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
    end else begin
      dispReg_q    <= dispReg_d;
      refreshCnt_q <= refreshCnt_d;
      digitIdx_q   <= digitIdx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with a short refresh period.
// Edge k counts rising edges after reset release; outputs after edge k show
// scan slot ((k-1)/4)%4 because of the one-cycle output register.
module tb_bcd_display_mux;

  logic        clk;
  logic        reset;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int compared;
  int mismatched;

  bcd_display_mux #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, then release while loading value (edge 1).
  task automatic applyStimulus(input logic [15:0] value, input logic blank);
    reset     = 1'b1;
    bcd_valid = 1'b0;
    step();
    step();
    reset     = 1'b0;
    bcd       = value;
    bcd_valid = 1'b1;
    blank_lz  = blank;
    step();
    bcd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bcd       = 16'h9999;
    bcd_valid = 1'b1;
    blank_lz  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL reset_hold: an=%b seg=%b dp=%b, required 1111 1111111 1", an, seg, dp);
      end
    end
    reset     = 1'b0;
    bcd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      compared++;
      if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL reset_release k=%0d: an=%b seg=%b dp=%b, required 1110 1000000 1", k, an, seg, dp);
      end
    end
  endtask

  task automatic test_scan_1331();
    logic [27:0] segExp;
    logic [15:0] anExp;
    int slot;
    segExp = {7'b1111001, 7'b0110000, 7'b0110000, 7'b1111001};
    anExp  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    applyStimulus(16'h1331, 1'b0);
    compared++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      mismatched++;
      $display("[TB] FAIL scan1331_latency: an=%b seg=%b, required 1110 1000000", an, seg);
    end
    for (int k = 2; k <= 21; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      compared++;
      if (an !== anExp[slot*4 +: 4] || seg !== segExp[slot*7 +: 7]) begin
        mismatched++;
        $display("[TB] FAIL scan1331 k=%0d: an=%b seg=%b, required %b %b", k, an, seg, anExp[slot*4 +: 4], segExp[slot*7 +: 7]);
      end
    end
  endtask

  task automatic test_zero_blank();
    logic [27:0] segExp;
    logic [15:0] anExp;
    int slot;
    segExp = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
    anExp  = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
    applyStimulus(16'h0000, 1'b1);
    for (int k = 2; k <= 17; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      compared++;
      if (an !== anExp[slot*4 +: 4] || seg !== segExp[slot*7 +: 7]) begin
        mismatched++;
        $display("[TB] FAIL zero_blank k=%0d: an=%b seg=%b, required %b %b", k, an, seg, anExp[slot*4 +: 4], segExp[slot*7 +: 7]);
      end
    end
    segExp = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    anExp  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    applyStimulus(16'h0000, 1'b0);
    for (int k = 2; k <= 17; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      compared++;
      if (an !== anExp[slot*4 +: 4] || seg !== segExp[slot*7 +: 7]) begin
        mismatched++;
        $display("[TB] FAIL zero_noblank k=%0d: an=%b seg=%b, required %b %b", k, an, seg, anExp[slot*4 +: 4], segExp[slot*7 +: 7]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] segExp;
    logic [15:0] anExp;
    int slot;
    segExp = {7'b1111111, 7'b0000000, 7'b1111001, 7'b0010000};
    anExp  = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
    applyStimulus(16'h0819, 1'b1);
    for (int k = 2; k <= 23; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      compared++;
      if (an !== anExp[slot*4 +: 4] || seg !== segExp[slot*7 +: 7]) begin
        mismatched++;
        $display("[TB] FAIL scan0819 k=%0d: an=%b seg=%b, required %b %b", k, an, seg, anExp[slot*4 +: 4], segExp[slot*7 +: 7]);
      end
    end
    // Edge 24 is a digit-advance edge; load the new word on it.
    bcd       = 16'h2048;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
    compared++;
    if (an !== 4'b1101 || seg !== 7'b1111001) begin
      mismatched++;
      $display("[TB] FAIL load_edge: an=%b seg=%b, required 1101 1111001", an, seg);
    end
    segExp = {7'b0100100, 7'b1000000, 7'b0011001, 7'b0000000};
    anExp  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    for (int k = 25; k <= 40; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      compared++;
      if (an !== anExp[slot*4 +: 4] || seg !== segExp[slot*7 +: 7]) begin
        mismatched++;
        $display("[TB] FAIL scan2048 k=%0d: an=%b seg=%b, required %b %b", k, an, seg, anExp[slot*4 +: 4], segExp[slot*7 +: 7]);
      end
    end
  endtask

  task automatic test_dash();
    logic [27:0] segExp;
    logic [15:0] anExp;
    int slot;
    segExp = {7'b1111111, 7'b1111111, 7'b0111111, 7'b0010010};
    anExp  = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
    applyStimulus(16'h00A5, 1'b1);
    for (int k = 2; k <= 17; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      compared++;
      if (an !== anExp[slot*4 +: 4] || seg !== segExp[slot*7 +: 7]) begin
        mismatched++;
        $display("[TB] FAIL dash k=%0d: an=%b seg=%b, required %b %b", k, an, seg, anExp[slot*4 +: 4], segExp[slot*7 +: 7]);
      end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(16'h4095, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      step();
    end
    // After edge 9 the hundreds slot (0) is showing and digit_idx is 2.
    compared++;
    if (an !== 4'b1011 || seg !== 7'b1000000) begin
      mismatched++;
      $display("[TB] FAIL mid_before: an=%b seg=%b, required 1011 1000000", an, seg);
    end
    reset = 1'b1;
    step();
    compared++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: an=%b seg=%b dp=%b, required 1111 1111111 1", an, seg, dp);
    end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      compared++;
      if (an !== 4'b1110 || seg !== 7'b1000000) begin
        mismatched++;
        $display("[TB] FAIL mid_release k=%0d: an=%b seg=%b, required 1110 1000000", k, an, seg);
      end
    end
    step();
    compared++;
    if (an !== 4'b1101 || seg !== 7'b1000000) begin
      mismatched++;
      $display("[TB] FAIL mid_tens: an=%b seg=%b, required 1101 1000000", an, seg);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    bcd        = 16'h0000;
    bcd_valid  = 1'b0;
    blank_lz   = 1'b0;
    #1;
    test_reset();
    test_scan_1331();
    test_zero_blank();
    test_back_to_back();
    test_dash();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, meaning clk cycles each digit is held, legal range >= 2; benches use 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 bcd  input  16  four packed BCD digits from the upstream binary-to-BCD converter; [15:12]=thousands, [3:0]=units.
REQ-005 bcd_valid  input  1  upstream ready strobe; bcd is sampled on any clk edge where it is high.
REQ-006 blank_lz  input  1  leading-zero blanking enable; sampled every cycle.
REQ-007 an  output  4  digit enables, active-low, one-hot-low or all-high.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low; held 1 (off) permanently.

Function
REQ-010 Capture: edge with bcd_valid=1 latches all 16 bits of bcd into disp_reg atomically; disp_reg holds otherwise.
REQ-011 Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0; digit_idx (2 bits) advances 0->1->2->3->0 on the edge where the counter is at REFRESH_DIV-1.
REQ-012 an, seg are registered: values on cycle n+1 derive from digit_idx, disp_reg, blank_lz at cycle n (one-cycle latency).
REQ-013 Unblanked slot: an[digit_idx]=0, other an bits 1; seg = decode of disp_reg nibble digit_idx.
REQ-014 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 Nibble 0xA-0xF decodes to dash 0111111; it is never blanked.
REQ-016 blank_lz=1: digit3 blank if d3=0; digit2 blank if d3=d2=0; digit1 blank if d3=d2=d1=0; digit0 never blank.
REQ-017 Blanked slot: an=1111, seg=1111111; scan timing unchanged.
REQ-018 blank_lz=0: no blanking; zeros display as 1000000.
REQ-019 bcd_valid coinciding with a digit advance: new value appears on the next cycle's outputs for all digits; no mixed old/new digits in any scanned slot.
REQ-020 bcd_valid held high continuously: disp_reg tracks bcd every cycle; no error.

Reset
REQ-021 Edge with reset=1: disp_reg=0, counter=0, digit_idx=0, an=1111, seg=1111111, dp=1; overrides bcd_valid on the same edge.
REQ-022 Reset mid-scan discards the latched value and scan position; first cycle after release drives digit 0 showing 0 (an=1110, seg=1000000).

Structure
REQ-023 Shared package bcd_disp_pkg holds the 7-segment constants (digits 0-9, dash, blank) and NUM_DIGITS=4.
REQ-024 Combinational sub-module seg7_decode (4-bit nibble in, 7-bit active-low seg out) implements REQ-014/015; instantiated once on the selected nibble.
REQ-025 No multicycle or clock-enable paths beyond the refresh counter; no latches.

Verification (REFRESH_DIV=4)
REQ-026 Reset for 2 cycles -> an=1111, seg=1111111, dp=1 during reset; after release an=1110, seg=1000000.
REQ-027 bcd=16'h1331, bcd_valid 1 cycle, blank_lz=0 -> slots 0..3 show 1,3,3,1 (seg 1111001,0110000,0110000,1111001) with an 1110,1101,1011,0111, each exactly 4 cycles.
REQ-028 bcd=16'h0000, blank_lz=1 -> slot 0 an=1110 seg=1000000; slots 1-3 an=1111 seg=1111111; blank_lz=0 -> all four show 1000000.
REQ-029 bcd=16'h0819, blank_lz=1 -> slot 3 blank; slots 2,1,0 show 8,1,9; then bcd=16'h2048 -> all four lit 2,0,4,8 from next cycle.
REQ-030 bcd=16'h00A5, blank_lz=1 -> slot 1 shows dash 0111111, slot 0 shows 5, slots 2-3 blank.
REQ-031 bcd=16'h4095 latched, reset pulsed while digit_idx=2 -> outputs reset next cycle; after release digit 0 shows 0 until a new bcd_valid.
